// File: rtl/count_seq_monitor.sv
// count_seq_monitor: watches an up/down counter, checks every step is +/-1 in the
// commanded direction, reports wraps and direction changes, and latches the first
// illegal step for debug.
module count_seq_monitor #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mon_en,
  input  logic              updown_in,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic              locked,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic              dir_chg,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              step_err,
  output logic [WIDTH-1:0]  err_exp,
  output logic [WIDTH-1:0]  err_got
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Value the counter must show one edge after `cur` when it was told `dir`.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] cur,
                                                input logic             dir);
    step_val = dir ? cur + WIDTH'(1) : cur - WIDTH'(1);
  endfunction

  // Saturating increment: sticks at all-ones.
  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    sat_inc = (&v) ? v : v + WRAP_W'(1);
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;

  // Reference sample (previous accepted C/D); pure data, loaded only on acceptance.
  logic [WIDTH-1:0]    r_ref_cnt;
  logic                r_ref_dir;

  logic                r_locked;
  logic                r_wrap_up;
  logic                r_wrap_dn;
  logic                r_dir_chg;
  logic [WRAP_W-1:0]   r_wrap_cnt;
  logic                r_step_err;
  logic [WIDTH-1:0]    r_err_exp;
  logic [WIDTH-1:0]    r_err_got;

  logic [WIDTH-1:0]    w_exp;
  logic                w_match;
  logic                w_is_wrap_up;
  logic                w_is_wrap_dn;
  logic                w_dir_diff;

  logic                w_ref_ld;
  logic                w_locked_nxt;
  logic                w_wrap_up_nxt;
  logic                w_wrap_dn_nxt;
  logic                w_dir_chg_nxt;
  logic [WRAP_W-1:0]   w_wrap_cnt_nxt;
  logic                w_step_err_nxt;
  logic [WIDTH-1:0]    w_err_exp_nxt;
  logic [WIDTH-1:0]    w_err_got_nxt;

  assign w_exp        = step_val(r_ref_cnt, r_ref_dir);
  assign w_match      = (cnt_in == w_exp);
  // A wrap is decided by where the counter came from and which way it was told to go.
  assign w_is_wrap_up = r_ref_dir  && (&r_ref_cnt);
  assign w_is_wrap_dn = !r_ref_dir && (r_ref_cnt == '0);
  assign w_dir_diff   = (updown_in != r_ref_dir);

  // State register; rst always wins and forces a resync.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: FAULT is only left through rst; disabling drops back to SYNC.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SYNC: begin
        if (mon_en) w_state_nxt = ST_TRACK;
      end
      ST_TRACK: begin
        if (!mon_en)      w_state_nxt = ST_SYNC;
        else if (!w_match) w_state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  // Next output values; pulses default low, counters and error capture hold.
  always_comb begin
    w_ref_ld       = 1'b0;
    w_locked_nxt   = 1'b0;
    w_wrap_up_nxt  = 1'b0;
    w_wrap_dn_nxt  = 1'b0;
    w_dir_chg_nxt  = 1'b0;
    w_wrap_cnt_nxt = r_wrap_cnt;
    w_step_err_nxt = r_step_err;
    w_err_exp_nxt  = r_err_exp;
    w_err_got_nxt  = r_err_got;
    case (r_state)
      ST_SYNC: begin
        if (mon_en) begin
          w_ref_ld     = 1'b1;
          w_locked_nxt = 1'b1;
        end
      end
      ST_TRACK: begin
        if (mon_en) begin
          if (w_match) begin
            w_ref_ld      = 1'b1;
            w_locked_nxt  = 1'b1;
            w_wrap_up_nxt = w_is_wrap_up;
            w_wrap_dn_nxt = w_is_wrap_dn;
            w_dir_chg_nxt = w_dir_diff;
            if (w_is_wrap_up || w_is_wrap_dn) w_wrap_cnt_nxt = sat_inc(r_wrap_cnt);
          end else begin
            // Mismatch beats any wrap decode; direction change is still reported.
            w_step_err_nxt = 1'b1;
            w_err_exp_nxt  = w_exp;
            w_err_got_nxt  = cnt_in;
            w_dir_chg_nxt  = w_dir_diff;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output registers; every output clears on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked   <= 1'b0;
      r_wrap_up  <= 1'b0;
      r_wrap_dn  <= 1'b0;
      r_dir_chg  <= 1'b0;
      r_wrap_cnt <= '0;
      r_step_err <= 1'b0;
      r_err_exp  <= '0;
      r_err_got  <= '0;
    end else begin
      r_locked   <= w_locked_nxt;
      r_wrap_up  <= w_wrap_up_nxt;
      r_wrap_dn  <= w_wrap_dn_nxt;
      r_dir_chg  <= w_dir_chg_nxt;
      r_wrap_cnt <= w_wrap_cnt_nxt;
      r_step_err <= w_step_err_nxt;
      r_err_exp  <= w_err_exp_nxt;
      r_err_got  <= w_err_got_nxt;
    end
  end

  // Reference sample capture; only meaningful once locked, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_ref_ld && !rst) begin
      r_ref_cnt <= cnt_in;
      r_ref_dir <= updown_in;
    end
  end

  assign locked   = r_locked;
  assign wrap_up  = r_wrap_up;
  assign wrap_dn  = r_wrap_dn;
  assign dir_chg  = r_dir_chg;
  assign wrap_cnt = r_wrap_cnt;
  assign step_err = r_step_err;
  assign err_exp  = r_err_exp;
  assign err_got  = r_err_got;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor: a behavioural counter drives the monitor, a
// behavioural model predicts every output each cycle, and directed scenarios pin
// the model with literal values. A second instance with WRAP_W=2 checks saturation.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       mon_en;
  logic       updown_in;
  logic [2:0] cnt_in;

  logic       locked, wrap_up, wrap_dn, dir_chg, step_err;
  logic [7:0] wrap_cnt;
  logic [2:0] err_exp, err_got;

  logic       locked2, wu2, wd2, dc2, se2;
  logic [1:0] wc2;
  logic [2:0] ee2, eg2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count_seq_monitor #(.WIDTH(3), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .mon_en(mon_en), .updown_in(updown_in), .cnt_in(cnt_in),
    .locked(locked), .wrap_up(wrap_up), .wrap_dn(wrap_dn), .dir_chg(dir_chg),
    .wrap_cnt(wrap_cnt), .step_err(step_err), .err_exp(err_exp), .err_got(err_got)
  );

  count_seq_monitor #(.WIDTH(3), .WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .mon_en(mon_en), .updown_in(updown_in), .cnt_in(cnt_in),
    .locked(locked2), .wrap_up(wu2), .wrap_dn(wd2), .dir_chg(dc2),
    .wrap_cnt(wc2), .step_err(se2), .err_exp(ee2), .err_got(eg2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         chk_en = 1'b0;
  bit         m_have, m_fault;
  logic [2:0] m_pc;
  bit         m_pd;
  bit         m_locked, m_wu, m_wd, m_dc, m_se;
  int         m_total;
  logic [2:0] m_exp, m_got;

  always @(posedge clk) begin
    logic [2:0] want;
    if (rst) begin
      chk_en = 1'b1;
      m_have = 0; m_fault = 0; m_total = 0;
      m_locked = 0; m_wu = 0; m_wd = 0; m_dc = 0; m_se = 0; m_exp = 0; m_got = 0;
    end else begin
      m_wu = 0; m_wd = 0; m_dc = 0;
      if (m_fault) begin
        m_locked = 0;
      end else if (!mon_en) begin
        m_have = 0; m_locked = 0;
      end else if (!m_have) begin
        m_have = 1; m_locked = 1; m_pc = cnt_in; m_pd = updown_in;
      end else begin
        want = m_pd ? 3'((int'(m_pc) + 1) % 8) : 3'((int'(m_pc) + 7) % 8);
        m_dc = (updown_in != m_pd);
        if (cnt_in == want) begin
          m_wu = m_pd && (m_pc == 3'd7);
          m_wd = !m_pd && (m_pc == 3'd0);
          if (m_wu || m_wd) m_total++;
          m_pc = cnt_in; m_pd = updown_in; m_locked = 1;
        end else begin
          m_fault = 1; m_have = 0; m_locked = 0;
          m_se = 1; m_exp = want; m_got = cnt_in;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      check("locked",   32'(locked),   32'(m_locked));
      check("wrap_up",  32'(wrap_up),  32'(m_wu));
      check("wrap_dn",  32'(wrap_dn),  32'(m_wd));
      check("dir_chg",  32'(dir_chg),  32'(m_dc));
      check("wrap_cnt", 32'(wrap_cnt), 32'((m_total > 255) ? 255 : m_total));
      check("step_err", 32'(step_err), 32'(m_se));
      check("err_exp",  32'(err_exp),  32'(m_exp));
      check("err_got",  32'(err_got),  32'(m_got));
      check("wrap_cnt_w2", 32'(wc2),   32'((m_total > 3) ? 3 : m_total));
      check("wrap_up_w2",  32'(wu2),   32'(m_wu));
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0] ctr;

  // One clock: the real counter advances by the direction it saw at this edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rst) ctr = 3'd0;
    else     ctr = updown_in ? ctr + 3'd1 : ctr - 3'd1;
    cnt_in = ctr;
  endtask

  task automatic run_until(input logic [2:0] v, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (cnt_in == v) begin
        ok = 1;
        return;
      end
      cyc();
    end
    ok = (cnt_in == v);
  endtask

  initial begin
    bit ok;
    int n;
    rst = 1; mon_en = 1; updown_in = 1; ctr = 0; cnt_in = 0;

    // 1: reset, lock, count up, wrap up
    repeat (5) cyc();
    check("reset_locked",   32'(locked),   32'd0);
    check("reset_wrap_cnt", 32'(wrap_cnt), 32'd0);
    check("reset_step_err", 32'(step_err), 32'd0);
    rst = 0;
    cyc();
    check("t1_locked", 32'(locked), 32'd1);
    repeat (7) cyc();
    check("t1_no_err", 32'(step_err), 32'd0);
    cyc();
    check("t1_wrap_up",  32'(wrap_up),  32'd1);
    check("t1_wrap_cnt", 32'(wrap_cnt), 32'd1);
    cyc();
    check("t1_wrap_up_gone", 32'(wrap_up), 32'd0);

    // 2: count down through 0 -> 7
    updown_in = 0;
    ok = 0;
    for (int i = 0; i < 16 && !ok; i++) begin
      cyc();
      if (wrap_dn) ok = 1;
    end
    check("t2_wrap_dn_seen", 32'(ok),       32'd1);
    check("t2_wrap_cnt",     32'(wrap_cnt), 32'd2);
    check("t2_no_err",       32'(step_err), 32'd0);

    // 3: reverse direction at cnt=3
    updown_in = 1;
    run_until(3'd3, ok);
    check("t3_reach3", 32'(ok), 32'd1);
    updown_in = 0;
    cyc();
    check("t3_dir_chg", 32'(dir_chg), 32'd1);
    cyc();
    check("t3_dir_chg_gone", 32'(dir_chg),  32'd0);
    check("t3_no_err",       32'(step_err), 32'd0);

    // 4: illegal step 2 -> 5 while counting up
    updown_in = 1;
    run_until(3'd2, ok);
    check("t4_reach2", 32'(ok), 32'd1);
    cyc();
    cnt_in = 3'd5;
    cyc();
    check("t4_step_err", 32'(step_err), 32'd1);
    check("t4_err_exp",  32'(err_exp),  32'd3);
    check("t4_err_got",  32'(err_got),  32'd5);
    for (int i = 0; i < 10; i++) begin
      updown_in = 1'($urandom);
      mon_en    = 1'($urandom);
      cyc();
      cnt_in = 3'($urandom);
    end
    check("t4_hold_err", 32'(step_err), 32'd1);
    check("t4_hold_exp", 32'(err_exp),  32'd3);
    check("t4_hold_got", 32'(err_got),  32'd5);
    mon_en = 1; rst = 1;
    cyc();
    check("t4_rst_err", 32'(step_err), 32'd0);
    check("t4_rst_exp", 32'(err_exp),  32'd0);
    check("t4_rst_got", 32'(err_got),  32'd0);
    rst = 0;

    // 6: disable mid-count and re-enable at cnt=6
    updown_in = 1;
    repeat (3) cyc();
    mon_en = 0;
    cyc();
    check("t6_unlocked", 32'(locked), 32'd0);
    updown_in = 0;
    run_until(3'd6, ok);
    check("t6_reach6", 32'(ok), 32'd1);
    mon_en = 1;
    cyc();
    check("t6_relocked", 32'(locked), 32'd1);
    repeat (5) cyc();
    check("t6_no_err", 32'(step_err), 32'd0);

    // 5: saturation of the wrap counter
    rst = 1;
    cyc();
    rst = 0; updown_in = 1;
    n = 0;
    repeat (45) begin
      cyc();
      if (wu2) n++;
    end
    check("t5_wc2_sat",     32'(wc2),    32'd3);
    check("t5_wu2_pulses",  32'(n >= 5), 32'd1);
    repeat (2100) cyc();
    check("t5_wc8_sat", 32'(wrap_cnt), 32'd255);

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) updown_in = ~updown_in;
      if ($urandom_range(0, 31) == 0) mon_en = ~mon_en;
      cyc();
      if ($urandom_range(0, 199) == 0) cnt_in = ctr ^ 3'($urandom_range(1, 7));
    end
    rst = 0;
    cyc();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
